gmii_tx_framer: RTL
===================

// Module: gmii_tx_framer
// PURPOSE
//  Transmit-side GMII framer; the send-path counterpart of the GMII receive path that feeds the system core.
//  Takes a byte stream with valid/ready/last framing from the switch core and drives gmii_txd/tx_en/tx_er toward rgmii_io.
//  Inserts preamble and SFD, pads short frames, appends the FCS, and enforces the inter-frame gap. One instance per port, clocked by the TX clock.
// PARAMETERS
//  PREAMBLE_LEN  7   count of 0x55 bytes sent before the SFD (0xD5)
//  MIN_PAYLOAD   60  minimum bytes before FCS; shorter frames are zero-padded to this length
//  IFG_LEN       12  idle cycles (tx_en=0) after the last frame byte
// PORTS
//  sys_clk          in   1   125 MHz TX clock; all logic on posedge
//  sys_rst_n        in   1   asynchronous active-low reset
//  tx_data          in   8   frame byte (DA first, no preamble, no FCS)
//  tx_valid         in   1   tx_data valid
//  tx_last          in   1   tx_data is the final byte of the frame
//  tx_ready         out  1   byte accepted on the edge where tx_valid&tx_ready
//  gmii_txd         out  8   GMII transmit data (registered)
//  gmii_tx_en       out  1   GMII transmit enable (registered)
//  gmii_tx_er       out  1   GMII transmit error (registered)
//  stat_frames      out  16  frames completed; wraps at 0xFFFF
//  stat_underruns   out  8   underrun events; saturates at 0xFF
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Asserting sys_rst_n mid-frame clears outputs immediately; the frame is truncated and tx_er is not raised.
//  States: IDLE -> PRE -> SFD -> DATA -> [PAD] -> [FCS] -> IFG -> IDLE. Underrun path: DATA -> ERR -> DROP -> IFG.
//  IDLE: tx_en=0, tx_ready=0. tx_valid=1 sampled at edge N -> PRE. gmii_txd=0x55 on cycles N+1..N+PREAMBLE_LEN, 0xD5 on the next cycle.
//  tx_ready is combinational: 1 in SFD and in DATA until tx_last is accepted; 0 in all other states except DROP.
//  A byte accepted at edge K appears on gmii_txd in cycle K+1. The first payload byte follows the SFD with no gap.
//  Byte count: 11 bits, saturating at 2047; counts payload plus pad bytes.
//  tx_last accepted with count < MIN_PAYLOAD -> PAD: send 0x00 until count == MIN_PAYLOAD, then FCS.
//  FCS: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) over payload and pad. Sent as 4 bytes, least-significant byte first.
//  IFG: exactly IFG_LEN cycles with tx_en=0, then IDLE. A tx_valid held high during IFG starts the next frame on the IFG exit edge, giving a gap of exactly IFG_LEN.
//  Underrun: tx_ready=1, tx_valid=0 in DATA (before tx_last) -> ERR for one cycle: tx_en=1, tx_er=1, txd=0x00. stat_underruns increments (saturating).
//  DROP: tx_en=0, tx_ready=1; discards bytes until tx_last is accepted, then IFG. The underrun frame is not counted in stat_frames.
//  stat_frames increments on the last FCS byte, or the last pad/data byte when the FCS is compiled out.
//  tx_er is 0 outside ERR. gmii_txd is 0x00 whenever tx_en=0.
// CONFIGURATION
//  GMII_TX_FCS_EN defined: behaviour as above; the framer generates and appends the FCS.
//  GMII_TX_FCS_EN undefined: no CRC logic and no FCS state. The upstream stream carries its own FCS. Pad target becomes MIN_PAYLOAD+4 (64), and IFG follows the last data/pad byte.
// TESTING
//  1 60-byte frame 0x00..0x3B, FCS_EN -> 7x0x55, 0xD5, 60 data, 4 FCS bytes matching zlib.crc32 LSB-first; tx_en high 72 cycles.
//  2 14-byte frame -> 46 bytes 0x00 padded; FCS over 60 bytes; tx_en high 72 cycles; stat_frames=1.
//  3 two 100-byte frames with tx_valid held high -> exactly 12 cycles tx_en=0 between them; stat_frames=2.
//  4 tx_valid dropped after byte 20 of a 100-byte frame -> one cycle tx_en=1/tx_er=1; remaining 80 bytes drained with tx_en=0; stat_underruns=1; next frame clean.
//  5 sys_rst_n low at payload byte 30 -> txd/tx_en/tx_er 0 within the same cycle; after release, a 60-byte frame is transmitted correctly.
//  6 FCS_EN undefined, 60-byte frame -> 4 zero pad bytes, tx_en high 72 cycles, no appended CRC.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, zero padding, optional FCS, IFG.
// Define GMII_TX_FCS_EN to build the CRC-32 generator and FCS state.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 60,
    parameter int IFG_LEN      = 12
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    input  logic        tx_last,
    output logic        tx_ready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic [15:0] stat_frames,
    output logic [7:0]  stat_underruns
);

`ifdef GMII_TX_FCS_EN
    localparam int PAD_TGT = MIN_PAYLOAD;
`else
    localparam int PAD_TGT = MIN_PAYLOAD + 4;
`endif
    localparam logic [10:0] PAD_N = 11'(PAD_TGT);
    localparam logic [7:0]  PRE_N = 8'(PREAMBLE_LEN);
    localparam logic [7:0]  IFG_N = 8'(IFG_LEN);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_ERR,
        S_DROP,
        S_IFG
`ifdef GMII_TX_FCS_EN
        , S_FCS
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [7:0]  txd_q, txd_d;
    logic        en_q, en_d;
    logic        er_q, er_d;
    logic [15:0] frames_q, frames_d;
    logic [7:0]  under_q, under_d;
    logic        put_byte;
    logic        body_end;
    logic [7:0]  byte_v;
    logic [10:0] cnt_inc;

`ifdef GMII_TX_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_inv;
    logic [1:0]  fcs_nxt;

    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign crc_inv = ~crc_q;
    assign fcs_nxt = tmr_q[1:0] + 2'd1;
`endif

    assign cnt_inc  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    assign tx_ready = (state_q == S_SFD)
                    | ((state_q == S_DATA) & ~last_q)
                    | (state_q == S_DROP);

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        txd_d    = 8'h00;
        en_d     = 1'b0;
        er_d     = 1'b0;
        frames_d = frames_q;
        under_d  = under_q;
        put_byte = 1'b0;
        body_end = 1'b0;
        byte_v   = 8'h00;
`ifdef GMII_TX_FCS_EN
        crc_d    = crc_q;
`endif
        unique case (state_q)
            S_IDLE, S_IFG: begin
                if (state_q == S_IFG && tmr_q != IFG_N) begin
                    tmr_d = tmr_q + 8'd1;
                end else if (tx_valid) begin
                    state_d = S_PRE;
                    tmr_d   = 8'd1;
                    txd_d   = 8'h55;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                    last_d  = 1'b0;
`ifdef GMII_TX_FCS_EN
                    crc_d   = 32'hFFFFFFFF;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE: begin
                en_d = 1'b1;
                if (tmr_q == PRE_N) begin
                    state_d = S_SFD;
                    txd_d   = 8'hD5;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                    txd_d = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                if (last_q) begin
                    if (cnt_q < PAD_N) begin
                        state_d  = S_PAD;
                        put_byte = 1'b1;
                    end else begin
                        body_end = 1'b1;
                    end
                end else if (tx_valid) begin
                    state_d  = S_DATA;
                    put_byte = 1'b1;
                    byte_v   = tx_data;
                    last_d   = tx_last;
                end else begin
                    // Upstream starved us mid-frame: poison it on the wire
                    state_d = S_ERR;
                    en_d    = 1'b1;
                    er_d    = 1'b1;
                    under_d = under_q + {7'd0, under_q != 8'hFF};
                end
            end
            S_PAD: begin
                if (cnt_q < PAD_N) put_byte = 1'b1;
                else               body_end = 1'b1;
            end
`ifdef GMII_TX_FCS_EN
            S_FCS: begin
                if (tmr_q == 8'd3) begin
                    state_d  = S_IFG;
                    tmr_d    = 8'd1;
                    frames_d = frames_q + 16'd1;
                end else begin
                    tmr_d = tmr_q + 8'd1;
                    en_d  = 1'b1;
                    txd_d = crc_inv[{fcs_nxt, 3'b000} +: 8];
                end
            end
`endif
            S_ERR: state_d = S_DROP;
            S_DROP: begin
                if (tx_valid && tx_last) begin
                    state_d = S_IFG;
                    tmr_d   = 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (put_byte) begin
            en_d  = 1'b1;
            txd_d = byte_v;
            cnt_d = cnt_inc;
`ifdef GMII_TX_FCS_EN
            crc_d = crc_step(crc_q, byte_v);
`endif
        end

        if (body_end) begin
`ifdef GMII_TX_FCS_EN
            state_d = S_FCS;
            tmr_d   = 8'd0;
            en_d    = 1'b1;
            txd_d   = crc_inv[7:0];
`else
            state_d  = S_IFG;
            tmr_d    = 8'd1;
            frames_d = frames_q + 16'd1;
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            tmr_q    <= '0;
            txd_q    <= '0;
            en_q     <= 1'b0;
            er_q     <= 1'b0;
            frames_q <= '0;
            under_q  <= '0;
`ifdef GMII_TX_FCS_EN
            crc_q    <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
            txd_q    <= txd_d;
            en_q     <= en_d;
            er_q     <= er_d;
            frames_q <= frames_d;
            under_q  <= under_d;
`ifdef GMII_TX_FCS_EN
            crc_q    <= crc_d;
`endif
        end
    end

    assign gmii_txd       = txd_q;
    assign gmii_tx_en     = en_q;
    assign gmii_tx_er     = er_q;
    assign stat_frames    = frames_q;
    assign stat_underruns = under_q;

endmodule
